// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
// 8N1 UART receiver with a small command decoder for an emulator debug port.
// The host sends single bytes. Every byte with a good stop bit is presented on
// data together with a one-cycle data_valid pulse. A few bytes also act as
// commands:
//   0x48 / 0x68 : toggle halted
//   0x52        : pulse reset_req and clear halted
//   0x53        : pulse step_req, only while halted
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (8..4095)
//   BIT_CNT_W    : width of the bit-timing counter
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset (deasserted synchronously upstream)
//   rx         : asynchronous serial input, idle high, LSB first
//   data       : last byte received with a good stop bit
//   data_valid : one-cycle pulse when data updates
//   frame_err  : one-cycle pulse when the stop bit samples low
//   halted     : halt state requested by the host (level)
//   reset_req  : one-cycle system reset request
//   step_req   : one-cycle single-step request (only while halted)
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int BIT_CNT_W    = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       halted,
    output logic       reset_req,
    output logic       step_req
);

    localparam logic [BIT_CNT_W-1:0] HALF_CNT = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] FULL_CNT = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] CNT_ONE  = BIT_CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state_reg, state_next;
    logic [BIT_CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [7:0]           shift_reg, shift_next;
    logic [7:0]           data_reg, data_next;
    logic                 data_valid_reg, data_valid_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 halted_reg, halted_next;
    logic                 reset_req_reg, reset_req_next;
    logic                 step_req_reg, step_req_next;

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a start bit.
    logic [1:0] sync_reg;
    logic       rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            halted_reg     <= 1'b0;
            reset_req_reg  <= 1'b0;
            step_req_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            data_reg       <= data_next;
            data_valid_reg <= data_valid_next;
            frame_err_reg  <= frame_err_next;
            halted_reg     <= halted_next;
            reset_req_reg  <= reset_req_next;
            step_req_reg   <= step_req_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        data_next       = data_reg;
        halted_next     = halted_reg;
        data_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        reset_req_next  = 1'b0;
        step_req_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end

            START: begin
                // Sample mid start bit; a line back high by then was a glitch.
                if (cnt_reg == HALF_CNT) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            DATA: begin
                if (cnt_reg == FULL_CNT) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            STOP: begin
                if (cnt_reg == FULL_CNT) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        // Returning straight to IDLE mid stop bit lets the
                        // next start edge be caught with no idle gap.
                        data_next       = shift_reg;
                        data_valid_next = 1'b1;
                        state_next      = IDLE;
                        case (shift_reg)
                            8'h48, 8'h68: halted_next = ~halted_reg;
                            8'h52: begin
                                reset_req_next = 1'b1;
                                halted_next    = 1'b0;
                            end
                            8'h53: step_req_next = halted_reg;
                            default: ;
                        endcase
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            WAIT_IDLE: begin
                // Hold off until the line returns high so a break reports once.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign data       = data_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign halted     = halted_reg;
    assign reset_req  = reset_req_reg;
    assign step_req   = step_req_reg;

endmodule
